alu_req_scheduler: RTL
======================

// Module: alu_req_scheduler
// PURPOSE
//  Shares one top_alu instance between two requesters (req0, req1) with round-robin arbitration.
//  Captures the winning request's opcode/operands, drives the ALU ports, waits the per-opcode latency.
//  Returns the 16-bit result to the winner through a valid/ready response channel tagged with its id.
//  Sits between the command sources and the ALU datapath. Owns the ALU's opcode/init/A/B/ex_sel inputs.
// PARAMETERS
//  W        8  operand width (ALU A/B width); the result is 2*W.
//  LAT_STD  1  ALU wait cycles for ADD/SUB/logic/CMP (opcodes 1,2,5-10,12).
//  LAT_MUL  2  ALU wait cycles for MUL (opcode 3).
//  LAT_DIV  4  ALU wait cycles for DIV (opcode 4).
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    asynchronous, active-low reset
//  req_valid    in   2    bit i = requester i has a command
//  req_ready    out  2    bit i = command i accepted this cycle
//  req0_opcode  in   4    req0 opcode (codebase ALU encoding)
//  req0_a       in   W    req0 operand A
//  req0_b       in   W    req0 operand B
//  req0_ex_sel  in   1    req0 ex_sel
//  req1_*       in   -    same as req0_*, for requester 1
//  rsp_valid    out  1    response available
//  rsp_ready    in   1    consumer takes response
//  rsp_id       out  1    requester index owning the response
//  rsp_data     out  2W   result
//  rsp_err      out  1    1 = illegal opcode or divide-by-zero
//  alu_opcode   out  4    to ALU
//  alu_init     out  1    to ALU
//  alu_a        out  W    to ALU
//  alu_b        out  W    to ALU
//  alu_ex_sel   out  1    to ALU
//  alu_result   in   2W   from ALU
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; rr pointer favours req0; req_ready=0; rsp_valid=0; rsp_id=0.
//   rsp_data=0; rsp_err=0; alu_opcode=0 (NOP); alu_init=0; alu_a=0; alu_b=0; alu_ex_sel=0.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: req_ready[i] is combinational = grant[i], and only in IDLE.
//   Grant: only one requester valid -> it wins. Both valid -> the requester not served last wins.
//   On accept: latch id/opcode/A/B/ex_sel and move to rr pointer update.
//   Short paths (no ALU issue):
//    opcode 0 or 11 -> RESP, data=0, err=0.
//    opcode 13-15 -> RESP, data=0, err=1.
//    opcode 4 with B=0 -> RESP, data=16'hFFFF, err=1.
//   Any other opcode -> ISSUE.
//  ISSUE (1 cycle): register alu_* from the latched request; alu_init=1; load wait cnt=LAT(opcode); -> WAIT.
//  WAIT: alu_* held stable; cnt decrements.
//   At cnt==1, capture alu_result into rsp_data, err=0 -> RESP.
//   Then alu_init=0 and alu_opcode=0.
//  RESP: rsp_valid=1; rsp_id/data/err held stable until rsp_valid&rsp_ready; then -> IDLE.
//   A new request is accepted no earlier than the cycle after the handshake.
//  Latency, accept edge T to rsp_valid high: short path 1 cycle; ALU path LAT+2 cycles
//   (ADD = 3, MUL = 4, DIV = 6 with defaults).
//  Width rules: ADD/SUB results are 2W wide, zero-extended; SUB wraps modulo 2^(2W).
//   The scheduler does not compute results; it passes alu_result through unmodified.
//  req_valid held with rsp stalled: no further accept; the requester waits (no overrun, no drop).
//  Reset mid-operation: in-flight command dropped, no response, all outputs to reset values immediately.
// STRUCTURE
//  Package alu_ctrl_pkg holds:
//   opcode localparams OP_NOP..OP_CMP (0-12), OP_REFRESH=11.
//   state encoding (IDLE/ISSUE/WAIT/RESP).
//   function lat_of(opcode).
//  Sub-module rr_arb2: 2-way round-robin grant.
//   Ports: clk, rst_n, req[1:0], ack, grant[1:0]; pointer updates on ack.
//  Top: FSM + request latch + wait counter + response register.
// TESTING (bench with a top_alu model plus a checker, as in the existing ALU bench)
//  1. req0 only ADD A=10 B=20, rsp_ready=1 -> rsp_valid 3 cycles after accept; id=0, data=30, err=0.
//  2. Both valid every cycle with MUL, rsp_ready=1 -> grants alternate 0,1,0,1.
//     data=A*B each time; reset first grant goes to req0.
//  3. DIV A=200 B=0 -> 1-cycle response, err=1, data=16'hFFFF, alu_init never asserts.
//     Opcode 14 -> err=1, data=0.
//  4. SUB A=5 B=9 with rsp_ready=0 for 5 cycles -> rsp_valid/data=16'hFFFC held.
//     req_ready stays 0 until the handshake completes.
//  5. rst_n low during WAIT of DIV -> all outputs reset asynchronously, no response after release.
//     The next req1 CMP A=B=7 returns data=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request scheduler: ALU opcode encoding,
// scheduler FSM state encoding, command classification and per-opcode latency.
package alu_ctrl_pkg;

    // ALU opcode encoding used across the codebase
    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_ADD     = 4'd1;
    localparam logic [3:0] OP_SUB     = 4'd2;
    localparam logic [3:0] OP_MUL     = 4'd3;
    localparam logic [3:0] OP_DIV     = 4'd4;
    localparam logic [3:0] OP_AND     = 4'd5;
    localparam logic [3:0] OP_OR      = 4'd6;
    localparam logic [3:0] OP_XOR     = 4'd7;
    localparam logic [3:0] OP_NOT     = 4'd8;
    localparam logic [3:0] OP_SHL     = 4'd9;
    localparam logic [3:0] OP_SHR     = 4'd10;
    localparam logic [3:0] OP_REFRESH = 4'd11;
    localparam logic [3:0] OP_CMP     = 4'd12;

    // Scheduler FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Width of the ALU wait counter (latencies up to 15 cycles)
    localparam int CNT_W = 4;

    // How an accepted command is handled
    typedef enum logic [1:0] {
        PATH_ALU     = 2'd0,  // issued to the ALU, result returned after the wait
        PATH_NULL    = 2'd1,  // NOP / REFRESH: answered at once with zero data
        PATH_ILLEGAL = 2'd2,  // unused opcodes: answered at once with an error
        PATH_DIV0    = 2'd3   // divide by zero: answered at once, all-ones data, error
    } path_e;

    // Number of ALU wait cycles for a given opcode
    function automatic logic [CNT_W-1:0] lat_of(
        input logic [3:0]       opcode,
        input logic [CNT_W-1:0] lat_std,
        input logic [CNT_W-1:0] lat_mul,
        input logic [CNT_W-1:0] lat_div
    );
        logic [CNT_W-1:0] lat;
        case (opcode)
            OP_MUL:  lat = lat_mul;
            OP_DIV:  lat = lat_div;
            default: lat = lat_std;
        endcase
        return lat;
    endfunction

    // Decide whether a command needs the ALU or can be answered directly
    function automatic path_e classify(
        input logic [3:0] opcode,
        input logic       b_zero
    );
        path_e path;
        case (opcode)
            OP_NOP, OP_REFRESH:    path = PATH_NULL;
            4'd13, 4'd14, 4'd15:   path = PATH_ILLEGAL;
            OP_DIV:                path = b_zero ? PATH_DIV0 : PATH_ALU;
            default:               path = PATH_ALU;
        endcase
        return path;
    endfunction

endpackage

// File: rtl/alu_req_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not served last wins. The pointer moves only when the
// grant is actually taken (ack), so an unconsumed grant does not rotate it.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] grant
);

    // Index of the requester served most recently; resets to 1 so req0 wins the first tie
    logic last_r;
    logic [1:0] grant_s;

    // Grant selection from the current requests and the last-served pointer
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_r ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    assign grant = grant_s;

    // Remember who was served when the grant is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (ack) begin
            last_r <= grant_s[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between two requesters. Accepts one command at a time via
// round-robin arbitration, drives the ALU for the opcode's latency, then
// returns the result tagged with the requester id on a valid/ready channel.
// Trivial commands (NOP/REFRESH, illegal opcodes, divide by zero) are answered
// without touching the ALU.
module alu_req_scheduler
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned LAT_STD = 1,
    parameter int unsigned LAT_MUL = 2,
    parameter int unsigned LAT_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [3:0]     req0_opcode,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req0_ex_sel,
    input  logic [3:0]     req1_opcode,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic           req1_ex_sel,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_data,
    output logic           rsp_err,
    output logic [3:0]     alu_opcode,
    output logic           alu_init,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic           alu_ex_sel,
    input  logic [2*W-1:0] alu_result
);

    localparam logic [CNT_W-1:0] LAT_STD_C = LAT_STD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAT_MUL_C = LAT_MUL[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LAT_DIV_C = LAT_DIV[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // FSM
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;

    // Arbitration and winner selection
    logic [1:0]       grant_s;
    logic             accept_s;
    logic             win_id_s;
    logic [3:0]       win_op_s;
    logic [W-1:0]     win_a_s;
    logic [W-1:0]     win_b_s;
    logic             win_ex_s;
    path_e            path_s;

    // Latched command
    logic [3:0]       op_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             ex_r;

    // ALU wait counter
    logic [CNT_W-1:0] cnt_r;
    logic             wait_done_s;

    // Response channel registers
    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [2*W-1:0]   rsp_data_r;
    logic             rsp_err_r;
    logic             rsp_hs_s;

    // ALU drive registers
    logic [3:0]       alu_opcode_r;
    logic             alu_init_r;
    logic [W-1:0]     alu_a_r;
    logic [W-1:0]     alu_b_r;
    logic             alu_ex_sel_r;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .ack   (accept_s),
        .grant (grant_s)
    );

    // Ready is offered only while idle; held low during reset so nothing is
    // handshaken while the block is being cleared
    always_comb begin
        if (rst_n && (state_r == ST_IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign accept_s    = (state_r == ST_IDLE) && (grant_s != 2'b00);
    assign wait_done_s = (state_r == ST_WAIT) && (cnt_r <= CNT_ONE);
    assign rsp_hs_s    = (state_r == ST_RESP) && rsp_valid_r && rsp_ready;

    // Pick the granted requester's command fields and classify the command
    always_comb begin
        win_id_s = grant_s[1];
        if (grant_s[1]) begin
            win_op_s = req1_opcode;
            win_a_s  = req1_a;
            win_b_s  = req1_b;
            win_ex_s = req1_ex_sel;
        end else begin
            win_op_s = req0_opcode;
            win_a_s  = req0_a;
            win_b_s  = req0_b;
            win_ex_s = req0_ex_sel;
        end
        path_s = classify(win_op_s, (win_b_s == {W{1'b0}}));
    end

    // Next-state logic of the scheduler FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (path_s == PATH_ALU) ? ST_ISSUE : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_done_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the winning command when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= OP_NOP;
            a_r  <= {W{1'b0}};
            b_r  <= {W{1'b0}};
            ex_r <= 1'b0;
        end else if (accept_s) begin
            op_r <= win_op_s;
            a_r  <= win_a_s;
            b_r  <= win_b_s;
            ex_r <= win_ex_s;
        end else begin
            op_r <= op_r;
            a_r  <= a_r;
            b_r  <= b_r;
            ex_r <= ex_r;
        end
    end

    // Wait counter: loaded with the opcode latency on issue, counts down while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            cnt_r <= lat_of(op_r, LAT_STD_C, LAT_MUL_C, LAT_DIV_C);
        end else if ((state_r == ST_WAIT) && !wait_done_s) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // ALU drive: present the command on issue, hold it through the wait,
    // release init and return the opcode to NOP once the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode_r <= OP_NOP;
            alu_init_r   <= 1'b0;
            alu_a_r      <= {W{1'b0}};
            alu_b_r      <= {W{1'b0}};
            alu_ex_sel_r <= 1'b0;
        end else if (state_r == ST_ISSUE) begin
            alu_opcode_r <= op_r;
            alu_init_r   <= 1'b1;
            alu_a_r      <= a_r;
            alu_b_r      <= b_r;
            alu_ex_sel_r <= ex_r;
        end else if (wait_done_s) begin
            alu_opcode_r <= OP_NOP;
            alu_init_r   <= 1'b0;
            alu_a_r      <= alu_a_r;
            alu_b_r      <= alu_b_r;
            alu_ex_sel_r <= alu_ex_sel_r;
        end else begin
            alu_opcode_r <= alu_opcode_r;
            alu_init_r   <= alu_init_r;
            alu_a_r      <= alu_a_r;
            alu_b_r      <= alu_b_r;
            alu_ex_sel_r <= alu_ex_sel_r;
        end
    end

    // Response register: id and short-path data on accept, ALU result at the
    // end of the wait; valid rises the cycle after entering RESP and drops on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_data_r  <= {(2*W){1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (accept_s) begin
                        rsp_id_r <= win_id_s;
                        case (path_s)
                            PATH_NULL: begin
                                rsp_data_r <= {(2*W){1'b0}};
                                rsp_err_r  <= 1'b0;
                            end
                            PATH_ILLEGAL: begin
                                rsp_data_r <= {(2*W){1'b0}};
                                rsp_err_r  <= 1'b1;
                            end
                            PATH_DIV0: begin
                                rsp_data_r <= {(2*W){1'b1}};
                                rsp_err_r  <= 1'b1;
                            end
                            default: begin
                                rsp_data_r <= rsp_data_r;
                                rsp_err_r  <= rsp_err_r;
                            end
                        endcase
                    end else begin
                        rsp_id_r   <= rsp_id_r;
                        rsp_data_r <= rsp_data_r;
                        rsp_err_r  <= rsp_err_r;
                    end
                end
                ST_WAIT: begin
                    rsp_valid_r <= 1'b0;
                    rsp_id_r    <= rsp_id_r;
                    if (wait_done_s) begin
                        rsp_data_r <= alu_result;
                        rsp_err_r  <= 1'b0;
                    end else begin
                        rsp_data_r <= rsp_data_r;
                        rsp_err_r  <= rsp_err_r;
                    end
                end
                ST_RESP: begin
                    rsp_valid_r <= !rsp_hs_s;
                    rsp_id_r    <= rsp_id_r;
                    rsp_data_r  <= rsp_data_r;
                    rsp_err_r   <= rsp_err_r;
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    rsp_id_r    <= rsp_id_r;
                    rsp_data_r  <= rsp_data_r;
                    rsp_err_r   <= rsp_err_r;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_id     = rsp_id_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;
    assign alu_opcode = alu_opcode_r;
    assign alu_init   = alu_init_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_ex_sel = alu_ex_sel_r;

endmodule
